// File: rtl/ffi_pkg.sv
// Shared types and constants for the gamma-window feed-forward inhibition block.
`ifndef NUM_SPIKES_DFLT
`define NUM_SPIKES_DFLT 8
`endif
`ifndef FFI_MAX_DFLT
`define FFI_MAX_DFLT 3
`endif

package ffi_pkg;

  // Window FSM: IDLE between windows, ACTIVE while admissions remain,
  // INHIBIT once the window budget is spent.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    INHIBIT = 2'd2
  } ffi_state_t;

  localparam int MODE_LEGACY = 0;
  localparam int MODE_BUDGET = 1;

  // Bits needed to hold the value max_val (never less than 1 bit).
  // Modules derive SCW/CW/STW from their own parameters with this rule.
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ffi_gamma_prio_admit.sv
// Lowest-index-first admission: admits the first rem active (low) spikes and
// reports the total spike count and the number admitted.
import ffi_pkg::*;

module ffi_prio_admit #(
  parameter int NUM_SPIKES = 8,
  parameter int CW         = 2,
  parameter int SCW        = 4
) (
  input  logic [NUM_SPIKES-1:0] spikes_l,
  input  logic [CW-1:0]         rem,
  output logic [NUM_SPIKES-1:0] admit,
  output logic [SCW-1:0]        spike_cnt,
  output logic [CW-1:0]         admit_cnt
);

  logic [SCW-1:0] run;

  // Prefix count: a spike is admitted while fewer than rem spikes precede it.
  always_comb begin
    run   = '0;
    admit = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      admit[i] = !spikes_l[i] && (int'(run) < int'(rem));
      run      = run + SCW'(!spikes_l[i]);
    end
    spike_cnt = run;
    admit_cnt = (int'(run) < int'(rem)) ? CW'(run) : rem;
  end

endmodule

// File: rtl/ffi_gamma.sv
// Gamma-window feed-forward inhibition with registered, 1-cycle-latency gating.
import ffi_pkg::*;

module ffi_gamma #(
  parameter  int NUM_SPIKES = `NUM_SPIKES_DFLT,
  parameter  int FFI_MAX    = `FFI_MAX_DFLT,
  parameter  int GAMMA_LEN  = 8,
  parameter  int MODE       = 1,
  localparam int CW         = (FFI_MAX < 1) ? 1 : $clog2(FFI_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gamma_start,
  input  logic                  step_valid,
  input  logic [NUM_SPIKES-1:0] should_spike_in_l,
  output logic [NUM_SPIKES-1:0] should_spike_out_l,
  output logic                  out_valid,
  output logic                  inhibit,
  output logic [CW-1:0]         admitted_cnt,
  output logic                  gamma_done,
  output ffi_state_t            dbg_state
);

  localparam int SCW = (NUM_SPIKES < 1) ? 1 : $clog2(NUM_SPIKES + 1);
  localparam int STW = (GAMMA_LEN < 1) ? 1 : $clog2(GAMMA_LEN + 1);

  // Handshake: step_valid is a one-cycle qualifier with no backpressure; a
  // step accepted on cycle t appears with out_valid=1 on cycle t+1, and
  // should_spike_out_l reads all ones whenever out_valid is low.

  ffi_state_t            state_q, state_d;
  logic [STW-1:0]        step_cnt_q, step_cnt_d;
  logic [CW-1:0]         admitted_cnt_q, admitted_cnt_d;
  logic                  inhibit_q, inhibit_d;
  logic [NUM_SPIKES-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  gamma_done_q, gamma_done_d;

  logic                  win_open;
  logic [STW-1:0]        eff_step;
  logic [CW-1:0]         eff_adm;
  logic                  eff_inh;
  logic [CW-1:0]         rem;
  logic [CW:0]           adm_sum;
  logic [CW-1:0]         new_adm;
  logic                  last_step;
  logic [NUM_SPIKES-1:0] admit;
  logic [SCW-1:0]        spike_cnt;
  logic [CW-1:0]         admit_cnt;

  ffi_prio_admit #(
    .NUM_SPIKES (NUM_SPIKES),
    .CW         (CW),
    .SCW        (SCW)
  ) u_admit (
    .spikes_l  (should_spike_in_l),
    .rem       (rem),
    .admit     (admit),
    .spike_cnt (spike_cnt),
    .admit_cnt (admit_cnt)
  );

  // Window as seen by this cycle's step: gamma_start restarts it in place, so a
  // same-cycle step is step 0 with a full budget.
  always_comb begin
    win_open  = gamma_start || (state_q != IDLE);
    eff_step  = gamma_start ? '0 : step_cnt_q;
    eff_adm   = gamma_start ? '0 : admitted_cnt_q;
    if (gamma_start) begin
      eff_inh = (MODE == MODE_BUDGET) && (FFI_MAX == 0);
    end else begin
      eff_inh = (state_q == INHIBIT);
    end
    rem       = CW'(FFI_MAX) - eff_adm;
    adm_sum   = {1'b0, eff_adm} + {1'b0, admit_cnt};
    new_adm   = (int'(adm_sum) >= FFI_MAX) ? CW'(FFI_MAX) : adm_sum[CW-1:0];
    last_step = (eff_step == STW'(GAMMA_LEN - 1));
  end

  // Next-state, counters and gated output for the step being accepted.
  always_comb begin
    state_d        = state_q;
    step_cnt_d     = step_cnt_q;
    admitted_cnt_d = admitted_cnt_q;
    out_d          = '1;
    out_valid_d    = 1'b0;
    gamma_done_d   = 1'b0;

    if (gamma_start) begin
      state_d        = eff_inh ? INHIBIT : ACTIVE;
      step_cnt_d     = '0;
      admitted_cnt_d = '0;
    end

    if (step_valid && win_open) begin
      out_valid_d = 1'b1;
      if (MODE == MODE_LEGACY) begin
        out_d = (int'(spike_cnt) < FFI_MAX) ? should_spike_in_l : '1;
      end else if (!eff_inh) begin
        out_d = should_spike_in_l | ~admit;
      end

      if (last_step) begin
        state_d        = IDLE;
        step_cnt_d     = '0;
        admitted_cnt_d = '0;
        gamma_done_d   = 1'b1;
      end else begin
        step_cnt_d = eff_step + STW'(1);
        if (MODE == MODE_BUDGET) begin
          admitted_cnt_d = new_adm;
          state_d        = (int'(new_adm) == FFI_MAX) ? INHIBIT : ACTIVE;
        end else begin
          state_d = ACTIVE;
        end
      end
    end

    inhibit_d = (state_d == INHIBIT);
  end

  // State and output registers; reset drops any in-flight step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      step_cnt_q     <= '0;
      admitted_cnt_q <= '0;
      inhibit_q      <= 1'b0;
      out_q          <= '1;
      out_valid_q    <= 1'b0;
      gamma_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_cnt_q     <= step_cnt_d;
      admitted_cnt_q <= admitted_cnt_d;
      inhibit_q      <= inhibit_d;
      out_q          <= out_d;
      out_valid_q    <= out_valid_d;
      gamma_done_q   <= gamma_done_d;
    end
  end

  assign should_spike_out_l = out_q;
  assign out_valid          = out_valid_q;
  assign inhibit            = inhibit_q;
  assign admitted_cnt       = admitted_cnt_q;
  assign gamma_done         = gamma_done_q;
  assign dbg_state          = state_q;

endmodule
